// File: rtl/alu_operand_fetch_if.sv
// Decoder-to-ALU operand fetch bus: instruction offer, write-back strobe and
// registered operand pair with valid/ready handshake.
interface alu_operand_fetch_if #(
    parameter int unsigned AW = 2,
    parameter int unsigned DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rs;
    logic [AW-1:0] in_rt;
    logic          in_use_imm;
    logic [DW-1:0] in_imm;
    logic          in_wr;
    logic [AW-1:0] in_rd;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;

    modport master (
        output in_valid, in_rs, in_rt, in_use_imm, in_imm, in_wr, in_rd,
        output wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, data1, data2
    );

    modport slave (
        input  in_valid, in_rs, in_rt, in_use_imm, in_imm, in_wr, in_rd,
        input  wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, data1, data2
    );
endinterface

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage: register file, pending scoreboard, write-back forwarding
// and a one-entry registered operand buffer feeding the ALU.
module alu_operand_fetch #(
    parameter int unsigned NREG = 4,
    parameter int unsigned AW   = 2,
    parameter int unsigned DW   = 8
) (
    input logic             clk,
    input logic             rst_n,
    alu_operand_fetch_if.slave bus
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    logic [DW-1:0]   rf [NREG];
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    logic          wb_hit_s;
    logic          wb_hit_t;
    logic [DW-1:0] fwd_s;
    logic [DW-1:0] fwd_t;
    logic          hz_s;
    logic          hz_t;
    logic          out_valid_c;
    logic          accept;

    assign out_valid_c   = (state == FULL);
    assign bus.out_valid = out_valid_c;

    // Forwarding and hazard detection for both source ports
    always_comb begin
        wb_hit_s = bus.wb_en && (bus.wb_addr == bus.in_rs);
        wb_hit_t = bus.wb_en && (bus.wb_addr == bus.in_rt);
        fwd_s    = wb_hit_s ? bus.wb_data : rf[bus.in_rs];
        fwd_t    = wb_hit_t ? bus.wb_data : rf[bus.in_rt];
        hz_s     = pending[bus.in_rs] && !wb_hit_s;
        hz_t     = !bus.in_use_imm && pending[bus.in_rt] && !wb_hit_t;
    end

    assign bus.in_ready = (!out_valid_c || bus.out_ready) && !(hz_s || hz_t);
    assign accept       = bus.in_valid && bus.in_ready;

    // Write-back clears first so an accepted writer to the same register wins
    always_comb begin
        pending_nxt = pending;
        if (bus.wb_en) begin
            pending_nxt[bus.wb_addr] = 1'b0;
        end
        if (accept && bus.in_wr) begin
            pending_nxt[bus.in_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            pending <= pending_nxt;
            if (bus.wb_en) begin
                rf[bus.wb_addr] <= bus.wb_data;
            end
        end
    end

    // Output buffer state machine; operands change only on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            bus.data1 <= '0;
            bus.data2 <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (!accept && bus.out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            if (accept) begin
                bus.data1 <= fwd_s;
                bus.data2 <= bus.in_use_imm ? bus.in_imm : fwd_t;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed bench for alu_operand_fetch with a behavioural reference model and
// per-cycle output comparison.
module tb_alu_operand_fetch;

    localparam int unsigned NREG = 4;
    localparam int unsigned AW   = 2;
    localparam int unsigned DW   = 8;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    alu_operand_fetch_if #(.AW(AW), .DW(DW)) bus ();

    alu_operand_fetch #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] mrf   [NREG];
    logic          mpend [NREG];
    logic          mvalid;
    logic [DW-1:0] md1;
    logic [DW-1:0] md2;

    function automatic logic [DW-1:0] mfwd(logic [AW-1:0] r);
        if (bus.wb_en && bus.wb_addr == r) return bus.wb_data;
        return mrf[r];
    endfunction

    function automatic logic exp_ready();
        logic stall_s;
        logic stall_t;
        stall_s = mpend[bus.in_rs] && !(bus.wb_en && bus.wb_addr == bus.in_rs);
        stall_t = !bus.in_use_imm && mpend[bus.in_rt] &&
                  !(bus.wb_en && bus.wb_addr == bus.in_rt);
        return (!mvalid || bus.out_ready) && !stall_s && !stall_t;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mvalid <= 1'b0;
            md1    <= '0;
            md2    <= '0;
            for (int i = 0; i < NREG; i++) begin
                mrf[i]   <= '0;
                mpend[i] <= 1'b0;
            end
        end else begin
            if (bus.wb_en) begin
                mrf[bus.wb_addr]   <= bus.wb_data;
                mpend[bus.wb_addr] <= 1'b0;
            end
            if (bus.in_valid && exp_ready()) begin
                md1    <= mfwd(bus.in_rs);
                md2    <= bus.in_use_imm ? bus.in_imm : mfwd(bus.in_rt);
                mvalid <= 1'b1;
                if (bus.in_wr) mpend[bus.in_rd] <= 1'b1;
            end else if (bus.out_ready) begin
                mvalid <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_out_valid", 32'(bus.out_valid), 32'(mvalid));
        check("model_in_ready", 32'(bus.in_ready), 32'(exp_ready()));
        if (mvalid) begin
            check("model_data1", 32'(bus.data1), 32'(md1));
            check("model_data2", 32'(bus.data2), 32'(md2));
        end
    end

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.in_rs      = '0;
        bus.in_rt      = '0;
        bus.in_use_imm = 1'b0;
        bus.in_imm     = '0;
        bus.in_wr      = 1'b0;
        bus.in_rd      = '0;
        bus.wb_en      = 1'b0;
        bus.wb_addr    = '0;
        bus.wb_data    = '0;
        bus.out_ready  = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic use_imm,
                         input logic [DW-1:0] imm, input logic wr, input logic [AW-1:0] rd);
        bus.in_valid   = 1'b1;
        bus.in_rs      = rs;
        bus.in_rt      = rt;
        bus.in_use_imm = use_imm;
        bus.in_imm     = imm;
        bus.in_wr      = wr;
        bus.in_rd      = rd;
    endtask

    task automatic wb(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_addr = addr;
        bus.wb_data = data;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data1", 32'(bus.data1), 32'h00);
        check("rst_data2", 32'(bus.data2), 32'h00);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        // First accept after reset reads zeroed registers
        offer(2'd1, 2'd2, 1'b0, 8'h00, 1'b0, 2'd0);
        tick();
        check("first_valid", 32'(bus.out_valid), 32'd1);
        check("first_data1", 32'(bus.data1), 32'h00);
        check("first_data2", 32'(bus.data2), 32'h00);

        // Same-cycle write-back is forwarded and then stored
        idle();
        offer(2'd1, 2'd0, 1'b1, 8'h03, 1'b0, 2'd0);
        wb(2'd1, 8'h5A);
        tick();
        check("fwd_data1", 32'(bus.data1), 32'h5A);
        check("fwd_data2", 32'(bus.data2), 32'h03);
        idle();
        offer(2'd0, 2'd1, 1'b0, 8'h00, 1'b0, 2'd0);
        tick();
        check("reread_data1", 32'(bus.data1), 32'h00);
        check("reread_data2", 32'(bus.data2), 32'h5A);

        // Backpressure holds the operand pair against a later write-back
        idle();
        wb(2'd0, 8'h11);
        tick();
        idle();
        offer(2'd0, 2'd0, 1'b1, 8'h44, 1'b0, 2'd0);
        tick();
        check("bp_data1", 32'(bus.data1), 32'h11);
        check("bp_data2", 32'(bus.data2), 32'h44);
        idle();
        bus.out_ready = 1'b0;
        offer(2'd1, 2'd1, 1'b0, 8'h00, 1'b0, 2'd0);
        wb(2'd0, 8'h22);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
            bus.wb_en = 1'b0;
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_data1", 32'(bus.data1), 32'h11);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("bp_next_data1", 32'(bus.data1), 32'h5A);
        check("bp_next_data2", 32'(bus.data2), 32'h5A);

        // Scoreboard stall until r3 is written back
        idle();
        offer(2'd0, 2'd0, 1'b1, 8'h00, 1'b1, 2'd3);
        tick();
        check("sb_writer_data1", 32'(bus.data1), 32'h22);
        idle();
        offer(2'd3, 2'd0, 1'b1, 8'h01, 1'b0, 2'd0);
        #1;
        check("sb_stall_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("sb_drained", 32'(bus.out_valid), 32'd0);
        #1;
        check("sb_stall_ready2", 32'(bus.in_ready), 32'd0);
        tick();
        wb(2'd3, 8'h7F);
        #1;
        check("sb_wb_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("sb_data1", 32'(bus.data1), 32'h7F);
        check("sb_data2", 32'(bus.data2), 32'h01);
        check("sb_valid", 32'(bus.out_valid), 32'd1);

        // Set wins over a same-cycle clear of the same register
        idle();
        offer(2'd0, 2'd0, 1'b1, 8'h00, 1'b1, 2'd2);
        tick();
        idle();
        offer(2'd0, 2'd0, 1'b1, 8'h00, 1'b1, 2'd2);
        wb(2'd2, 8'h33);
        #1;
        check("sw_accept_ready", 32'(bus.in_ready), 32'd1);
        tick();
        idle();
        offer(2'd2, 2'd0, 1'b1, 8'h00, 1'b0, 2'd0);
        #1;
        check("sw_stall_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("sw_drained", 32'(bus.out_valid), 32'd0);
        wb(2'd2, 8'h55);
        tick();
        check("sw_data1", 32'(bus.data1), 32'h55);

        // Reset while FULL and stalled clears everything at once
        idle();
        offer(2'd3, 2'd0, 1'b1, 8'h09, 1'b1, 2'd1);
        tick();
        check("mr_data1", 32'(bus.data1), 32'h7F);
        check("mr_data2", 32'(bus.data2), 32'h09);
        idle();
        bus.out_ready = 1'b0;
        tick();
        check("mr_full_valid", 32'(bus.out_valid), 32'd1);
        offer(2'd1, 2'd1, 1'b0, 8'h00, 1'b0, 2'd0);
        #1;
        check("mr_pre_ready", 32'(bus.in_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(bus.out_valid), 32'd0);
        check("mr_data1_clr", 32'(bus.data1), 32'h00);
        check("mr_data2_clr", 32'(bus.data2), 32'h00);
        check("mr_pending_clr", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("mr_after_valid", 32'(bus.out_valid), 32'd1);
        check("mr_after_data1", 32'(bus.data1), 32'h00);
        check("mr_after_data2", 32'(bus.data2), 32'h00);

        idle();
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_fetch.md
# alu_operand_fetch

Operand-fetch stage directly upstream of the ALU. Holds the 4 × 8-bit general register file, reads two source operands (or one register plus an immediate) for each accepted instruction, and presents them registered on `data1`/`data2` to the ALU with a valid/ready handshake. A per-register pending scoreboard stalls instructions whose sources are still awaiting write-back. Same-cycle write-back data is forwarded.

## Interface
- `NREG`, default 4: number of registers; must be a power of two.
- `AW`, default 2: register address width, log2(`NREG`).
- `DW`, default 8: datapath width.

- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: the decoder is offering an instruction.
- `in_ready`  out  1: the stage accepts the instruction this cycle (combinational).
- `in_rs`  in  AW: source register for `data1`.
- `in_rt`  in  AW: source register for `data2`; ignored when `in_use_imm` is 1.
- `in_use_imm`  in  1: drive `data2` from `in_imm`.
- `in_imm`  in  DW: immediate operand.
- `in_wr`  in  1: the instruction will write back to `in_rd`.
- `in_rd`  in  AW: destination register.
- `wb_en`  in  1: write-back strobe from downstream.
- `wb_addr`  in  AW: write-back register.
- `wb_data`  in  DW: write-back data.
- `out_valid`  out  1: `data1`/`data2` hold a valid operand pair.
- `out_ready`  in  1: the ALU side consumes the pair.
- `data1`  out  DW: operand A, registered.
- `data2`  out  DW: operand B, registered.

## Operation
- **Register file:** `NREG` × `DW`. Every entry resets to 0. On `wb_en` at a clock edge, `rf[wb_addr] <= wb_data`.
- **Scoreboard:** `pending[NREG]`, reset to all 0.
  - An accepted instruction with `in_wr` = 1 sets `pending[in_rd]`.
  - `wb_en` clears `pending[wb_addr]`.
  - If both target the same register in the same cycle, the set wins.
- **Forwarding:** `fwd(r)` = `wb_data` if `wb_en` and `wb_addr == r`, otherwise `rf[r]`.
- **Hazard:**
  - `hz_s` = `pending[in_rs]` and not (`wb_en` and `wb_addr == in_rs`).
  - `hz_t` = not `in_use_imm` and `pending[in_rt]` and not (`wb_en` and `wb_addr == in_rt`).
- **Handshake:** `in_ready` = (not `out_valid` or `out_ready`) and not (`hz_s` or `hz_t`).
- **Accept** = `in_valid` and `in_ready`. At the clock edge:
  - `data1 <= fwd(in_rs)`.
  - `data2 <=` `in_imm` if `in_use_imm`, otherwise `fwd(in_rt)`.
  - `out_valid <= 1`.
- **Drain:** if `out_valid` and `out_ready` and no accept, then `out_valid <= 0`. `data1`/`data2` keep their last values.
- **Hold:** while `out_valid` = 1 and `out_ready` = 0, `data1`, `data2` and `out_valid` are frozen. A write-back during the hold does not modify the held operands.
- **Output state machine:** EMPTY (`out_valid` = 0) and FULL (`out_valid` = 1).
  - EMPTY → FULL on accept.
  - FULL → FULL on accept, or when `out_ready` = 0.
  - FULL → EMPTY when `out_ready` = 1 and no accept.
- **Arithmetic and width:** no arithmetic in this stage. Addresses are exactly `AW` bits, so no out-of-range index is possible.
- **Reset mid-operation:** `rst_n` low immediately clears `out_valid`, `data1`, `data2`, every `pending` bit and every register, regardless of any in-flight handshake.

## Timing
- Latency: an instruction accepted at edge N appears on `data1`/`data2` with `out_valid` = 1 after edge N.
- Throughput: one instruction per cycle when `out_ready` is held at 1 and there are no hazards.
- `in_ready` is combinational from `out_valid`, `out_ready`, `in_*`, `wb_*` and `pending`. Upstream must not make `in_valid` depend on `in_ready`.
- Reset values: `out_valid` = 0, `data1` = 0, `data2` = 0. During reset, `in_ready` = 1 whenever no hazard exists; all `pending` bits are 0 at that point.
- A write-back and an accept in the same cycle:
  - The register file is written.
  - The forwarded value is captured.
  - The pending bit resolves per the set-wins rule.

## Test plan
- **Reset:** after `rst_n` deassert, accept `rs`=1, `rt`=2 → `data1`=0x00, `data2`=0x00, `out_valid`=1 one cycle later.
- **Forwarding:** `wb_en`=1, `wb_addr`=1, `wb_data`=0x5A in the same cycle as accepting `rs`=1, `use_imm`=1, `imm`=0x03 → `data1`=0x5A, `data2`=0x03. A next read of r1 also returns 0x5A.
- **Backpressure:**
  - Accept A (r0=0x11), then hold `out_ready`=0 for 3 cycles → `in_ready`=0, `data1` stays 0x11.
  - During the hold, `wb` r0=0x22 → `data1` still 0x11.
  - On release → the next pair appears.
- **Scoreboard stall:**
  - Accept an instruction with `in_wr`=1, `rd`=3.
  - Offer `rs`=3 → `in_ready`=0 until `wb_en`, `wb_addr`=3, `wb_data`=0x7F. It is accepted that cycle with `data1`=0x7F.
- **Set-wins:** with r2 pending, accept `in_wr`=1, `rd`=2 while `wb` clears r2 → `pending[2]` stays 1, and the next `rs`=2 instruction stalls.
- **Reset mid-stall:** assert `rst_n`=0 while FULL with `out_ready`=0 → `out_valid`=0, `data1`=`data2`=0 immediately, and all `pending` bits clear.
